// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StRsp    = 3'd5
  } master_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: one outstanding single-beat read or write per local command.
// Every output is a flop, so next-state logic also computes next-cycle output values.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  master_state_e         state_q, state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        // The two channels may complete in any order or together.
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid && bready) begin
          resp_d  = bresp;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRdReq: begin
        if (arvalid && arready) state_d = StRdResp;
      end
      StRdResp: begin
        if (rvalid && rready) begin
          resp_d  = rresp;
          rdata_d = rdata;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_valid && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    awvalid_d   = (state_d == StWrReq) && !aw_done_d;
    wvalid_d    = (state_d == StWrReq) && !w_done_d;
    bready_d    = (state_d == StWrResp);
    arvalid_d   = (state_d == StRdReq);
    rready_d    = (state_d == StRdResp);
    rsp_valid_d = (state_d == StRsp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cmd_ready <= cmd_ready_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      bready    <= bready_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_write = write_q;
  assign rsp_resp  = resp_q;
  assign rsp_rdata = rdata_q;

endmodule
